car_sensor_conditioner: RTL and testbench
=========================================

Name: car_sensor_conditioner

Overview:
- Upstream stage of the highway/country traffic-signal controller; produces the controller's country-road car request `X`.
- Cleans the raw roadside loop-sensor signal: 2-flop synchronizer, then a stability debounce.
- Latches a car request until the controller serves it with country GREEN.
- Suppresses a stuck-high sensor so the highway cannot be starved.

Parameters:
- DEB_CYCLES, 4: consecutive synchronized samples that must disagree with the debounced level before it flips (≥1).
- STUCK_CYCLES, 256: consecutive cycles of debounced presence that declare the sensor stuck (≥2).
- GREEN_CODE, 2'd2: encoding of GREEN on the controller's 2-bit light outputs (RED=0, YELLOW=1, GREEN=2).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- clear  in  1  synchronous, active-high reset.
- sensor_raw  in  1  asynchronous raw loop-sensor level; 1 = car present.
- cntry  in  2  country-road light state fed back from the signal controller.
- X  out  1  car request to the signal controller.
- presence  out  1  debounced sensor level.
- fault  out  1  stuck-sensor indication.

Behaviour:
- Reset: one clock is the only clock. Reset is synchronous and active-high on `clear`, which has priority over everything else. On reset:
  - sync flops = 0, debounce counter = 0, presence = 0, stuck counter = 0;
  - state = IDLE; X = 0, fault = 0.
  - Reset mid-request drops X on the next edge.
- Synchronizer: s1 <= sensor_raw; s2 <= s1.
- Debounce, evaluated each edge:
  - if s2 == presence: counter <= 0;
  - else if counter == DEB_CYCLES-1: presence <= s2, counter <= 0;
  - else counter <= counter+1.
  - Net effect: a raw change must persist for DEB_CYCLES synchronized samples. Shorter glitches are discarded.
- Stuck counter:
  - Cleared whenever presence = 0.
  - Otherwise increments, saturating at STUCK_CYCLES.
  - stuck_hit = (stuck counter == STUCK_CYCLES-1) && presence.
- State machine, registered; evaluated in priority order per state:
  - IDLE:
    - presence=1 and stuck_hit -> FAULT;
    - presence=1 -> REQUEST.
  - REQUEST:
    - stuck_hit -> FAULT (priority over grant);
    - cntry==GREEN_CODE -> SERVING.
    - Presence dropping does not cancel the request (car already detected, latched).
  - SERVING:
    - stuck_hit -> FAULT;
    - cntry!=GREEN_CODE -> REQUEST if presence=1, else IDLE.
  - FAULT:
    - presence=0 -> IDLE;
    - otherwise stay.
- Outputs, decoded from registered signals only (no path from sensor_raw or cntry):
  - X = 1 in REQUEST; X = presence in SERVING; X = 0 in IDLE and FAULT.
  - fault = 1 only in FAULT.
- Latency, counting the first edge that samples sensor_raw=1 as edge 1:
  - presence rises after edge DEB_CYCLES+2;
  - X rises after edge DEB_CYCLES+3 (edge 7 at default).
  - Falling presence follows the same DEB_CYCLES+2 path.
- SERVING hand-back: X falls with presence. This lets the controller end country green.
- Widths:
  - debounce counter = $clog2(DEB_CYCLES)+1 bits;
  - stuck counter = $clog2(STUCK_CYCLES)+1 bits;
  - no wrap-around; both counters saturate or clear.

Test Plan:
1. Reset: clear=1 for 2 clocks with sensor_raw=1 -> X, presence, fault all 0 during reset; after release, X rises after edge 7.
2. Glitch rejection, DEB_CYCLES=4: sensor_raw high for 3 clocks then low -> presence and X stay 0 throughout.
3. Latched request: sensor_raw high 10 clocks then low, cntry held RED -> X rises at edge 7 and stays 1 after presence drops. Then drive cntry=GREEN -> next edge state SERVING, X=0; cntry back to RED -> IDLE, X=0.
4. Serving with car present: sensor_raw held high, cntry=GREEN for 20 clocks then YELLOW -> X=1 during green; next edge after YELLOW -> REQUEST, X stays 1.
5. Stuck sensor, STUCK_CYCLES=16: sensor_raw held high, cntry RED -> after 16 cycles of presence, fault=1 and X=0. Then sensor_raw low -> after DEB_CYCLES+2 edges presence=0, next edge fault=0 (IDLE).
6. Simultaneous events, STUCK_CYCLES=16: in REQUEST, cntry=GREEN on the same edge as stuck_hit -> FAULT wins, X=0, fault=1. Separately, assert clear while in SERVING -> next edge X=0, fault=0, IDLE.

Source files
------------

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner
//   Front end for the highway/country traffic-signal controller. It cleans the raw
//   country-road loop sensor and produces the controller's car request X.
//   Processing chain: 2-flop synchronizer -> stability debounce -> request latch FSM.
//   A sensor that reads "present" for too long is declared stuck, so that it cannot
//   hold the highway on red indefinitely.
//
// Ports
//   clock       in   system clock, rising edge
//   clear       in   synchronous active-high reset, highest priority
//   sensor_raw  in   asynchronous raw loop-sensor level (1 = car present)
//   cntry [1:0] in   country-road light state fed back from the controller
//   X           out  car request to the controller
//   presence    out  debounced sensor level
//   fault       out  stuck-sensor indication
module car_sensor_conditioner #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 256,
    parameter logic [1:0]  GREEN_CODE   = 2'd2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       sensor_raw,
    input  logic [1:0] cntry,
    output logic       X,
    output logic       presence,
    output logic       fault
);

    localparam int unsigned DebW   = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned StuckW = $clog2(STUCK_CYCLES) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StServing,
        StFault
    } state_e;

    logic              s1_q, s2_q;
    logic [DebW-1:0]   deb_cnt_q;
    logic              presence_q;
    logic [StuckW-1:0] stuck_cnt_q;
    logic              stuck_hit;
    state_e            state_q, state_d;

    // Synchronizer for the asynchronous sensor level.
    always_ff @(posedge clock) begin
        if (clear) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sensor_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (clear) begin
            deb_cnt_q  <= '0;
            presence_q <= 1'b0;
        end else if (s2_q == presence_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
            presence_q <= s2_q;
            deb_cnt_q  <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    // Length of the current presence run, saturating so it never wraps.
    always_ff @(posedge clock) begin
        if (clear) begin
            stuck_cnt_q <= '0;
        end else if (!presence_q) begin
            stuck_cnt_q <= '0;
        end else if (stuck_cnt_q != StuckW'(STUCK_CYCLES)) begin
            stuck_cnt_q <= stuck_cnt_q + 1'b1;
        end
    end

    assign stuck_hit = presence_q && (stuck_cnt_q == StuckW'(STUCK_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (presence_q && stuck_hit) begin
                    state_d = StFault;
                end else if (presence_q) begin
                    state_d = StRequest;
                end
            end
            StRequest: begin
                // Stuck detection outranks a grant; a dropped presence keeps the request.
                if (stuck_hit) begin
                    state_d = StFault;
                end else if (cntry == GREEN_CODE) begin
                    state_d = StServing;
                end
            end
            StServing: begin
                if (stuck_hit) begin
                    state_d = StFault;
                end else if (cntry != GREEN_CODE) begin
                    state_d = presence_q ? StRequest : StIdle;
                end
            end
            StFault: begin
                if (!presence_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs come from registers only; in SERVING, X follows presence so the
    // controller can end country green once the car has left.
    always_comb begin
        X     = 1'b0;
        fault = 1'b0;
        unique case (state_q)
            StIdle:    X = 1'b0;
            StRequest: X = 1'b1;
            StServing: X = presence_q;
            StFault:   fault = 1'b1;
            default:   X = 1'b0;
        endcase
    end

    assign presence = presence_q;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Bench for car_sensor_conditioner with DEB_CYCLES=4 and STUCK_CYCLES=16.
// Directed scenarios with spec-derived constants, then randomized traffic checked
// against a behavioural model built from the sensor history and request rules.
module tb_car_sensor_conditioner;

    localparam int unsigned Deb   = 4;
    localparam int unsigned Stuck = 16;
    localparam logic [1:0]  Green = 2'd2;

    logic       clock;
    logic       clear;
    logic       sensor_raw;
    logic [1:0] cntry;
    logic       X;
    logic       presence;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    car_sensor_conditioner #(
        .DEB_CYCLES  (Deb),
        .STUCK_CYCLES(Stuck),
        .GREEN_CODE  (Green)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .sensor_raw(sensor_raw),
        .cntry     (cntry),
        .X         (X),
        .presence  (presence),
        .fault     (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model.
    // hist holds the last Deb+1 raw samples (oldest first); the debounced level at an
    // edge flips when every raw sample taken 2..Deb+1 edges earlier disagrees with it.
    bit hist[$];
    bit m_pres;
    int m_run;      // cycles presence has been continuously high (capped)
    bit m_req;      // a car request is latched
    bit m_serve;    // country green is serving the request
    bit m_fault;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= int'(Deb); i++) hist.push_back(1'b0);
        m_pres  = 1'b0;
        m_run   = 0;
        m_req   = 1'b0;
        m_serve = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge(input bit r, input logic [1:0] c, input bit clr);
        bit stuck_now;
        bit all_differ;
        bit green;
        if (clr) begin
            model_reset();
            return;
        end
        stuck_now = m_pres && (m_run == int'(Stuck) - 1);
        green     = (c == Green);
        all_differ = 1'b1;
        for (int i = 0; i < int'(Deb); i++) if (hist[i] == m_pres) all_differ = 1'b0;

        if (m_fault) begin
            if (!m_pres) m_fault = 1'b0;
        end else if (stuck_now && (m_pres || m_req || m_serve)) begin
            m_fault = 1'b1;
            m_req   = 1'b0;
            m_serve = 1'b0;
        end else if (m_serve) begin
            if (!green) begin
                m_serve = 1'b0;
                m_req   = m_pres;
            end
        end else if (m_req) begin
            if (green) begin
                m_req   = 1'b0;
                m_serve = 1'b1;
            end
        end else if (m_pres) begin
            m_req = 1'b1;
        end

        m_run = m_pres ? ((m_run < int'(Stuck)) ? m_run + 1 : m_run) : 0;
        if (all_differ) m_pres = ~m_pres;
        hist.push_back(r);
        void'(hist.pop_front());
    endtask

    function automatic logic exp_x();
        return logic'(m_req || (m_serve && m_pres));
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
    task automatic cyc(input logic r, input logic [1:0] c, input logic clr);
        sensor_raw = r;
        cntry      = c;
        clear      = clr;
        @(posedge clock);
        model_edge(r, c, clr);
        @(negedge clock);
        chk("model_x", X, exp_x());
        chk("model_presence", presence, logic'(m_pres));
        chk("model_fault", fault, logic'(m_fault));
    endtask

    initial begin
        int raw_left;
        int c_left;
        logic r;
        logic [1:0] c;

        sensor_raw = 1'b1;
        cntry      = 2'd0;
        clear      = 1'b1;
        model_reset();

        // Reset with the sensor high, then request latency from release.
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        chk("rst_x", X, 1'b0);
        chk("rst_presence", presence, 1'b0);
        chk("rst_fault", fault, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 0);
            chk("lat_x", X, logic'(i >= 7));
            chk("lat_presence", presence, logic'(i >= 6));
        end

        // Latched request survives the car leaving, then green serves it.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
        chk("latch_x", X, 1'b1);
        chk("latch_presence", presence, 1'b0);
        cyc(0, 2, 0);
        chk("serve_empty_x", X, 1'b0);
        cyc(0, 0, 0);
        chk("idle_x", X, 1'b0);
        chk("idle_fault", fault, 1'b0);

        // Glitch of three clocks is discarded.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            chk("glitch_presence", presence, 1'b0);
            chk("glitch_x", X, 1'b0);
        end

        // Serving with the car still present, then yellow returns to request.
        cyc(1, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2, 0);
            chk("serve_x", X, 1'b1);
        end
        cyc(1, 1, 0);
        chk("yellow_req_x", X, 1'b1);
        chk("yellow_fault", fault, 1'b0);

        // Stuck sensor: fault after Stuck cycles of presence, clears once presence drops.
        cyc(1, 0, 1);
        for (int i = 1; i <= 22; i++) begin
            cyc(1, 0, 0);
            chk("stuck_fault", fault, logic'(i >= 22));
        end
        chk("stuck_x", X, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 0, 0);
            chk("unstuck_fault", fault, logic'(i <= 6));
            chk("unstuck_presence", presence, logic'(i <= 5));
        end

        // Green arriving on the same edge as the stuck hit: fault wins.
        cyc(1, 0, 1);
        for (int i = 0; i < 21; i++) cyc(1, 0, 0);
        chk("pre_tie_x", X, 1'b1);
        cyc(1, 2, 0);
        chk("tie_fault", fault, 1'b1);
        chk("tie_x", X, 1'b0);

        // Clear while serving drops the request on the next edge.
        cyc(1, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0);
        cyc(1, 2, 0);
        chk("serving_x", X, 1'b1);
        cyc(1, 2, 1);
        chk("clr_serve_x", X, 1'b0);
        chk("clr_serve_fault", fault, 1'b0);

        // Randomized traffic against the model.
        cyc(0, 0, 1);
        raw_left = 0;
        c_left   = 0;
        r        = 1'b0;
        c        = 2'd0;
        for (int n = 0; n < 1500; n++) begin
            if (raw_left == 0) begin
                r        = logic'($urandom_range(0, 1));
                raw_left = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 30))
                                                       : int'($urandom_range(1, 8));
            end
            if (c_left == 0) begin
                c      = 2'($urandom_range(0, 2));
                c_left = int'($urandom_range(1, 12));
            end
            cyc(r, c, logic'($urandom_range(0, 199) == 0));
            raw_left--;
            c_left--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
